// File: rtl/add15_serial_checker_if.sv
// Operand/result bundle between the adder under test, its driver and the serial checker.
// Latency: none, wires only.
// Backpressure: none; the driver watches BUSY and holds off START while a check runs.
interface add15_serial_checker_if #(
  parameter int WIDTH = 15,
  parameter int CNT_W = 8
);
  logic             START;
  logic             SUB;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] C;
  logic             OVF;
  logic             CLR_CNT;
  logic             BUSY;
  logic             DONE;
  logic             PASS;
  logic [WIDTH-1:0] EXP;
  logic             EXP_OVF;
  logic [CNT_W-1:0] TEST_CNT;
  logic [CNT_W-1:0] ERR_CNT;

  // Requester side: applies the operation and observes the verdict.
  modport master (
    output START, SUB, A, B, C, OVF, CLR_CNT,
    input  BUSY, DONE, PASS, EXP, EXP_OVF, TEST_CNT, ERR_CNT
  );

  // Checker side.
  modport slave (
    input  START, SUB, A, B, C, OVF, CLR_CNT,
    output BUSY, DONE, PASS, EXP, EXP_OVF, TEST_CNT, ERR_CNT
  );
endinterface

// File: rtl/add15_serial_checker.sv
// Bit-serial re-computation of a latched add/sub result, with pass/fail and saturating counters.
// Latency: DONE pulses WIDTH edges after the edge that samples START; BUSY spans WIDTH+2 cycles.
// Backpressure: START is only sampled in IDLE; a START seen while BUSY is dropped, not queued.
module add15_serial_checker #(
  parameter int WIDTH = 15,
  parameter int CNT_W = 8
) (
  input  logic                 CLK,
  input  logic                 RSTN,
  add15_serial_checker_if.slave bus
);

  localparam int              IW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0]   LAST    = IW'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, SHIFT, CMP} state_t;

  state_t           state;
  state_t           state_nxt;

  // Shadow copies of the operation under test, frozen for the whole check.
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] c_sh;
  logic             sub_sh;
  logic             ovf_sh;

  // Serial adder state.
  logic [WIDTH-1:0] acc;
  logic             carry;
  logic [IW-1:0]    idx;

  // Registered outputs.
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic             exp_ovf_q;
  logic [WIDTH-1:0] exp_q;
  logic [CNT_W-1:0] test_cnt_q;
  logic [CNT_W-1:0] err_cnt_q;

  // Current bit slice and the verdict that is committed on the final shift.
  logic             ai;
  logic             bi;
  logic             s;
  logic             cout;
  logic             last_bit;
  logic [WIDTH-1:0] exp_fin;
  logic             ovf_fin;
  logic             pass_fin;

  // One full-adder slice; on the MSB, 'carry' is the carry into that bit, so
  // signed overflow is simply carry-in xor carry-out of the top bit.
  always_comb begin
    ai       = a_sh[idx];
    bi       = b_sh[idx] ^ sub_sh;
    s        = ai ^ bi ^ carry;
    cout     = (ai & bi) | (ai & carry) | (bi & carry);
    last_bit = (state == SHIFT) && (idx == LAST);
    exp_fin  = {s, acc[WIDTH-1:1]};
    ovf_fin  = carry ^ cout;
    pass_fin = (exp_fin == c_sh) && (ovf_fin == ovf_sh);
  end

  // State register.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state: one accept cycle, WIDTH shift cycles, one compare cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.START) state_nxt = SHIFT;
      SHIFT:   if (idx == LAST) state_nxt = CMP;
      CMP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, serial accumulation and result registers.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      a_sh      <= '0;
      b_sh      <= '0;
      c_sh      <= '0;
      sub_sh    <= 1'b0;
      ovf_sh    <= 1'b0;
      acc       <= '0;
      carry     <= 1'b0;
      idx       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      exp_ovf_q <= 1'b0;
      exp_q     <= '0;
    end else begin
      done_q <= last_bit;
      case (state)
        IDLE: begin
          if (bus.START) begin
            a_sh   <= bus.A;
            b_sh   <= bus.B;
            c_sh   <= bus.C;
            sub_sh <= bus.SUB;
            ovf_sh <= bus.OVF;
            carry  <= bus.SUB;
            idx    <= '0;
            acc    <= '0;
            busy_q <= 1'b1;
          end
        end
        SHIFT: begin
          acc   <= exp_fin;
          carry <= cout;
          idx   <= idx + 1'b1;
          if (idx == LAST) begin
            exp_q     <= exp_fin;
            exp_ovf_q <= ovf_fin;
            pass_q    <= pass_fin;
          end
        end
        CMP: begin
          busy_q <= 1'b0;
        end
        default: begin
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  // Saturating test/error counters; a clear wins over a same-cycle increment.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      test_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else if (bus.CLR_CNT) begin
      test_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else if (last_bit) begin
      if (test_cnt_q != CNT_MAX) test_cnt_q <= test_cnt_q + 1'b1;
      if (!pass_fin && (err_cnt_q != CNT_MAX)) err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  assign bus.BUSY     = busy_q;
  assign bus.DONE     = done_q;
  assign bus.PASS     = pass_q;
  assign bus.EXP      = exp_q;
  assign bus.EXP_OVF  = exp_ovf_q;
  assign bus.TEST_CNT = test_cnt_q;
  assign bus.ERR_CNT  = err_cnt_q;

endmodule

// File: doc/add15_serial_checker.md
# add15_serial_checker

Sequential self-checking consumer for the 15-bit CLA adder/subtractor. It sits on the adder's output side. On a START request it latches the adder's operands (A, B, SUB) and its results (C, OVF), then recomputes the expected result one bit per clock with a bit-serial ripple adder. It compares the expected and captured values, reports pass/fail, and keeps saturating test and error counters. The block is used on-board and in simulation to confirm the combinational adder, one operation at a time.

## Interface
Parameters:
- WIDTH, 15, operand/result width in bits (two's complement).
- CNT_W, 8, width of the test and error counters.

Ports:
- CLK  in  1  single system clock; all state changes on the rising edge.
- RSTN  in  1  asynchronous, active-low reset.
- START  in  1  request a check; sampled only in IDLE.
- SUB  in  1  operation under test: 0 = A+B, 1 = A−B.
- A  in  WIDTH  operand A as applied to the adder.
- B  in  WIDTH  operand B as applied to the adder (before any SUB inversion).
- C  in  WIDTH  adder result C[WIDTH-1:0].
- OVF  in  1  adder signed-overflow flag.
- CLR_CNT  in  1  synchronous clear of TEST_CNT and ERR_CNT.
- BUSY  out  1  high while a check is in progress.
- DONE  out  1  one-cycle pulse when PASS/EXP/EXP_OVF become valid.
- PASS  out  1  1 when C==EXP and OVF==EXP_OVF for the last check.
- EXP  out  WIDTH  expected result.
- EXP_OVF  out  1  expected overflow.
- TEST_CNT  out  CNT_W  checks completed, saturating.
- ERR_CNT  out  CNT_W  failed checks, saturating.

## Operation
- States: IDLE, SHIFT, CMP.
- IDLE: START=1 latches A, B, SUB, C and OVF into shadow registers. It also sets carry=SUB, bit index=0 and clears the EXP accumulator. Next state is SHIFT.
- SHIFT: one bit per cycle, LSB first, for index i.
  - bi = B[i]^SUB.
  - s = A[i]^bi^carry.
  - carry ← majority(A[i], bi, carry).
  - s is shifted into EXP from the MSB side, so EXP is LSB-aligned after WIDTH shifts.
  - At i = WIDTH−1, the carry-in to that bit is saved as cin_msb.
  - After WIDTH cycles (i = WIDTH−1), next state is CMP.
- CMP, one cycle:
  - EXP_OVF ← cin_msb ^ carry_out_msb.
  - PASS ← (EXP==C_latched) && (EXP_OVF==OVF_latched).
  - DONE=1.
  - TEST_CNT increments, saturating at 2^CNT_W−1.
  - ERR_CNT increments, saturating, when the check fails.
  - Next state is IDLE.
- Arithmetic is modulo 2^WIDTH. Overflow is signed overflow only. The final carry-out is not reported.
- START while BUSY is ignored: it is not queued. Shadow registers are frozen from the IDLE sample until the next accepted START, so input changes during a check have no effect.
- CLR_CNT has priority over an increment in the same cycle: both counters become 0.
- PASS, EXP and EXP_OVF hold their values until the next CMP.

## Timing
- Reset (RSTN=0, asynchronous):
  - State=IDLE.
  - BUSY=0, DONE=0, PASS=0.
  - EXP=0, EXP_OVF=0.
  - TEST_CNT=0, ERR_CNT=0.
  - All shadow registers 0.
- Reset mid-check aborts the check: no DONE and no counter update. After release, the next START begins a fresh check.
- START is sampled at edge k.
- BUSY=1 from edge k through edge k+WIDTH+1. SHIFT occupies edges k+1 … k+WIDTH, and CMP is entered at edge k+WIDTH.
- DONE=1 and results are valid in the cycle after edge k+WIDTH. That is 16 cycles after START for WIDTH=15.
- BUSY and DONE fall at edge k+WIDTH+1.
- Back-to-back: a START seen at edge k+WIDTH+1 (IDLE) is accepted. Minimum spacing is WIDTH+2 cycles.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset: assert RSTN=0 mid-SHIFT. All outputs go to 0 immediately. Release and START with A=0, B=0, SUB=0, C=0, OVF=0 → PASS=1, TEST_CNT=1.
- Add with overflow: A=9650, B=9356, SUB=0, C=19006 (0x4A3E), OVF=1 → DONE 16 cycles after START, EXP=0x4A3E, EXP_OVF=1, PASS=1, ERR_CNT=0.
- Subtract: A=4181, B=0x7C18 (−1000), SUB=1, C=5181, OVF=0 → EXP=5181, EXP_OVF=0, PASS=1. Then A=0x5AF3 (−9485), B=9786, SUB=1, C=13497, OVF=1 → EXP=0x34B9, EXP_OVF=1, PASS=1.
- Mismatch: A=8431, B=1534, SUB=0, C=9964, OVF=0 → EXP=9965, PASS=0, ERR_CNT increments by 1.
- Busy handling: pulse START again 5 cycles into a check, and change A/B/C mid-check → exactly one DONE. Results reflect the originally latched values. TEST_CNT increments by 1.
- Counters:
  - Force 255 failing checks, then one more → ERR_CNT=255 and TEST_CNT=255 (saturated).
  - Assert CLR_CNT in the DONE cycle → both counters 0 on the next cycle.
